// File: rtl/i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_rx_fifo
//   Receive-side sample buffer for the I2S path. The I2S receiver core pushes
//   one {channel, sample} entry per strobe into a circular FIFO. The management
//   SoC drains the FIFO and reads status over a Wishbone classic slave port.
//   A level/overflow interrupt drives one user_irq line.
//
// Parameters
//   DEPTH    : FIFO entries, power of two, 4..128
//   SAMPLE_W : sample width in bits, 8..24
//
// Ports
//   wb_clk_i, wb_rst_ni         : clock, async active-low reset
//   smp_valid_i/data_i/chan_i   : sample strobe, two's-complement data, 0=L 1=R
//   wbs_cyc_i/stb_i/we_i/sel_i  : Wishbone classic cycle controls
//   wbs_adr_i, wbs_dat_i        : address (bits [3:2] decoded), write data
//   wbs_ack_o, wbs_dat_o        : acknowledge, read data (0 outside ack)
//   irq_o                       : registered level-sensitive interrupt
//
// Register map (wbs_adr_i[3:2])
//   0 DATA   RO, pop : [31] chan, [30:SAMPLE_W] sign ext, [SAMPLE_W-1:0] sample
//   1 STATUS         : [0] EMPTY [1] FULL [2] OVERFLOW w1c [3] UNDERFLOW w1c
//                      [15:8] LEVEL
//   2 CTRL   RW      : [0] EN, [1] FLUSH (write-1 pulse), [15:8] THRESH
//   3 IRQ_EN RW      : [0] LEVEL_IE, [1] OVF_IE
//
// Configuration
//   I2S_RX_FIFO_IRQ_EN : when defined, the IRQ_EN register and irq_o logic are
//                        built. Otherwise irq_o is 0 and IRQ_EN reads 0.
// -----------------------------------------------------------------------------
module i2s_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                smp_valid_i,
  input  logic [SAMPLE_W-1:0] smp_data_i,
  input  logic                smp_chan_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = SAMPLE_W + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_addr_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;
  logic          en_q,     en_d;
  logic [7:0]    thresh_q, thresh_d;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          pop_ok_q;
  logic          level_ie_q, ovf_ie_q;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  reg_addr_e adr;
  logic      wb_req, commit, wr_commit, rd_commit;
  logic      empty, full;

  assign adr    = reg_addr_e'(wbs_adr_i[3:2]);
  assign wb_req = wbs_cyc_i & wbs_stb_i & ~ack_q;

  // The ack register is qualified by the live cycle so a master that drops
  // cyc during the ack cycle sees no ack and nothing is committed.
  assign wbs_ack_o = ack_q & wbs_cyc_i & wbs_stb_i;
  assign wbs_dat_o = wbs_ack_o ? dat_q : 32'h0;

  assign commit    = wbs_ack_o;
  assign wr_commit = commit & wbs_we_i;
  assign rd_commit = commit & ~wbs_we_i;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  // ---------------------------------------------------------------------------
  // Read data mux (sampled in the request cycle)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] head;
  logic [31:0]   rd_data;

  assign head = mem_q[rd_ptr_q];

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_data = 32'h0;
    unique case (adr)
      REG_DATA: begin
        if (!empty)
          rd_data = {head[EW-1], {(31-SAMPLE_W){head[SAMPLE_W-1]}},
                     head[SAMPLE_W-1:0]};
      end
      REG_STATUS: rd_data = {16'h0, 8'(level_q), 4'h0, unf_q, ovf_q, full, empty};
      REG_CTRL:   rd_data = {16'h0, thresh_q, 6'h0, 1'b0, en_q};
      REG_IRQ_EN: rd_data = {30'h0, ovf_ie_q, level_ie_q};
      default:    rd_data = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs regardless of order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      pop_ok_q <= 1'b0;
    end else begin
      ack_q    <= wb_req;
      dat_q    <= (wb_req & ~wbs_we_i) ? rd_data : 32'h0;
      // Decide the pop when the data is captured: a sample pushed between
      // capture and commit must not be consumed by a read that returned 0.
      pop_ok_q <= wb_req & ~wbs_we_i & (adr == REG_DATA) & ~empty;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO and register next state
  // ---------------------------------------------------------------------------
  logic push_req, push_ok, pop, flush;

  assign pop      = rd_commit & pop_ok_q;
  assign flush    = wr_commit & (adr == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
  assign push_req = smp_valid_i & en_q;
  assign push_ok  = push_req & ~flush & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    en_d     = en_q;
    thresh_d = thresh_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push_ok) level_d = level_q - 1'b1;
    end

    // W1C first, so a set in the same cycle wins.
    if (wr_commit && adr == REG_STATUS && wbs_sel_i[0]) begin
      if (wbs_dat_i[2]) ovf_d = 1'b0;
      if (wbs_dat_i[3]) unf_d = 1'b0;
    end
    if (push_req && full && !pop && !flush) ovf_d = 1'b1;
    if (rd_commit && adr == REG_DATA && !pop_ok_q) unf_d = 1'b1;

    if (wr_commit && adr == REG_CTRL) begin
      if (wbs_sel_i[0]) en_d     = wbs_dat_i[0];
      if (wbs_sel_i[1]) thresh_d = wbs_dat_i[15:8];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      en_q     <= 1'b0;
      thresh_q <= 8'd1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      en_q     <= en_d;
      thresh_q <= thresh_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only observable through
  // rd_ptr/level, which are reset, so clearing it would buy nothing.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {smp_chan_i, smp_data_i};
  end

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
`ifdef I2S_RX_FIFO_IRQ_EN
  logic irq_q, irq_cond;

  assign irq_cond = (level_ie_q & (8'(level_q) >= thresh_q) & (thresh_q != 8'h0))
                  | (ovf_ie_q & ovf_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      level_ie_q <= 1'b0;
      ovf_ie_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_commit && adr == REG_IRQ_EN && wbs_sel_i[0]) begin
        level_ie_q <= wbs_dat_i[0];
        ovf_ie_q   <= wbs_dat_i[1];
      end
      irq_q <= irq_cond;
    end
  end

  assign irq_o = irq_q;
`else
  assign level_ie_q = 1'b0;
  assign ovf_ie_q   = 1'b0;
  assign irq_o      = 1'b0;
`endif

  // Address, byte-lane and data bits that no register decodes.
  logic unused_bus;
  assign unused_bus = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i};

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_fifo
//   Self-checking bench for i2s_rx_fifo (DEPTH=16, SAMPLE_W=24). Expected DATA
//   words are queued as samples are driven and compared as they are read back.
// -----------------------------------------------------------------------------
module tb_i2s_rx_fifo;

  localparam int DEPTH = 16;
`ifdef I2S_RX_FIFO_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smp_valid;
  logic [23:0] smp_data;
  logic        smp_chan;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  i2s_rx_fifo #(.DEPTH(DEPTH), .SAMPLE_W(24)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .smp_valid_i(smp_valid),
    .smp_data_i (smp_data),
    .smp_chan_i (smp_chan),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .irq_o      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic ch, input logic [23:0] d);
    return {ch, {7{d[23]}}, d};
  endfunction

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    q = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = {28'h0, a, 2'b00}; wdat = d;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack) break;
    end
    if (n == 8) check("ack_timeout", 32'h0, 32'h1);
    else q = rdat;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_rd(input logic [1:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'h0, q);
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_rd(a, q);
    check(tag, q, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] q, exp;
    wb_rd(2'd0, q);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      exp = sb.pop_front();
      check(tag, q, exp);
    end
  endtask

  task automatic push(input logic ch, input logic [23:0] d, input logic accept);
    @(posedge clk); #1;
    smp_valid = 1'b1; smp_chan = ch; smp_data = d;
    @(posedge clk); #1;
    smp_valid = 1'b0;
    if (accept) sb.push_back(word(ch, d));
  endtask

  initial begin
    logic [31:0] q, exp;
    logic [23:0] d;

    rst_n = 1'b0; smp_valid = 1'b0; smp_data = '0; smp_chan = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;

    // Reset register values, then underflow on empty read.
    rd_check("rst_status", 2'd1, 32'h0000_0001);
    rd_check("rst_ctrl",   2'd2, 32'h0000_0100);
    rd_check("rst_irq_en", 2'd3, 32'h0000_0000);
    rd_check("empty_data", 2'd0, 32'h0000_0000);
    @(negedge clk);
    check("ack_one_cycle", {31'h0, ack}, 32'h0);
    rd_check("unf_status", 2'd1, 32'h0000_0009);
    wb_wr(2'd1, 32'h8);
    rd_check("unf_clear", 2'd1, 32'h0000_0001);

    // Strobes ignored while disabled.
    push(1'b0, 24'h123456, 1'b0);
    rd_check("dis_status", 2'd1, 32'h0000_0001);

    // Extreme samples with sign extension.
    wb_wr(2'd2, 32'h0000_0101);
    push(1'b0, 24'h7FFFFF, 1'b1);
    push(1'b1, 24'h800000, 1'b1);
    rd_check("lvl2_status", 2'd1, 32'h0000_0200);
    pop_check("data_L_max");
    pop_check("data_R_min");
    rd_check("drain_status", 2'd1, 32'h0000_0001);

    // Overfill by one: 17th sample dropped, OVERFLOW set.
    for (int i = 0; i <= DEPTH; i++) begin
      d = 24'($urandom);
      push(i[0], d, i < DEPTH);
    end
    rd_check("full_status", 2'd1, 32'h0000_1006);
    for (int i = 0; i < DEPTH; i++) pop_check("fill_data");
    rd_check("ovf_empty_status", 2'd1, 32'h0000_0005);
    wb_wr(2'd1, 32'h4);
    rd_check("ovf_clear", 2'd1, 32'h0000_0001);

    // Full FIFO, push strobe exactly in the ack cycle of a DATA read.
    for (int i = 0; i < DEPTH; i++) push(1'b0, 24'($urandom), 1'b1);
    d = 24'hA5A5A5;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
    @(posedge clk); #1;
    smp_valid = 1'b1; smp_chan = 1'b1; smp_data = d;
    @(negedge clk);
    check("full_rd_ack", {31'h0, ack}, 32'h1);
    q = rdat;
    @(posedge clk); #1;
    smp_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
    exp = sb.pop_front();
    check("full_rd_data", q, exp);
    sb.push_back(word(1'b1, d));
    rd_check("full_pushpop_status", 2'd1, 32'h0000_1002);
    for (int i = 0; i < DEPTH; i++) pop_check("pushpop_data");
    rd_check("pushpop_drain", 2'd1, 32'h0000_0001);

    // Level interrupt: THRESH=4, LEVEL_IE=1.
    wb_wr(2'd2, 32'h0000_0401);
    wb_wr(2'd3, 32'h0000_0001);
    rd_check("irq_en_rb", 2'd3, {31'h0, IRQ_BUILT});
    for (int i = 0; i < 3; i++) push(1'b0, 24'(i + 1), 1'b1);
    check("irq_lvl3", {31'h0, irq}, 32'h0);
    push(1'b1, 24'h000004, 1'b1);       // level reads 4 in this cycle
    @(negedge clk);
    check("irq_latency", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_rise", {31'h0, irq}, {31'h0, IRQ_BUILT});
    pop_check("irq_pop");               // level reads 3 in this cycle
    @(negedge clk);
    check("irq_hold", {31'h0, irq}, {31'h0, IRQ_BUILT});
    @(negedge clk);
    check("irq_fall", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) pop_check("irq_drain");
    wb_wr(2'd3, 32'h0);

    // FLUSH concurrent with a push strobe.
    push(1'b0, 24'h111111, 1'b0);
    push(1'b1, 24'h222222, 1'b0);
    rd_check("preflush_status", 2'd1, 32'h0000_0200);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h8; wdat = 32'h0000_0103;
    @(posedge clk); #1;
    smp_valid = 1'b1; smp_chan = 1'b0; smp_data = 24'h333333;
    @(negedge clk);
    check("flush_ack", {31'h0, ack}, 32'h1);
    @(posedge clk); #1;
    smp_valid = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd_check("flush_status", 2'd1, 32'h0000_0001);
    rd_check("flush_ctrl", 2'd2, 32'h0000_0101);
    rd_check("flush_data", 2'd0, 32'h0000_0000);
    rd_check("flush_unf", 2'd1, 32'h0000_0009);
    check("sb_leftover", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
